// File: rtl/rsa_pkg.sv
// rsa_pkg: definitions shared by the modular-exponentiation sequencer and its
// helpers.
//   modexp_state_t : sequencer states
//   N_DEFAULT      : default operand / modulus width
//   MM_ONE         : the constant 1, used as the second operand of the
//                    Montgomery multiply that converts out of the Montgomery
//                    domain
package rsa_pkg;

    localparam int N_DEFAULT = 1024;

    localparam logic [N_DEFAULT-1:0] MM_ONE = {{(N_DEFAULT-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_X   = 3'd1,
        ST_SQ       = 3'd2,
        ST_MUL      = 3'd3,
        ST_CONV_OUT = 3'd4,
        ST_DONE     = 3'd5
    } modexp_state_t;

endpackage

// File: rtl/exp_scanner.sv
// exp_scanner: holds the latched exponent and walks a bit index from the MSB
// down to bit 0.
//   clk, reset : clock, synchronous active-high reset (clears e and k)
//   load       : latch e_in and set k = E_BITS-1
//   step       : k <= k-1 (saturates at 0)
//   e_in       : exponent to latch
//   cur_bit    : e[k]
//   last_bit   : k == 0
module exp_scanner
    import rsa_pkg::*;
#(
    parameter int E_BITS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [E_BITS-1:0] e_in,
    output logic              cur_bit,
    output logic              last_bit
);

    localparam int KW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

    logic [E_BITS-1:0] e_reg;
    logic [KW-1:0]     k_reg;
    logic [E_BITS-1:0] hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_reg <= '0;
            k_reg <= '0;
        end else if (load) begin
            e_reg <= e_in;
            k_reg <= KW'(E_BITS - 1);
        end else if (step && (k_reg != '0)) begin
            k_reg <= k_reg - 1'b1;
        end
    end

    // One-hot select of e[k]; avoids a variable index whose width would not
    // match E_BITS when E_BITS is not a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < E_BITS; gi++) begin : g_sel
            assign hit[gi] = e_reg[gi] && (k_reg == KW'(gi));
        end
    endgenerate

    assign cur_bit  = |hit;
    assign last_bit = (k_reg == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: computes result = in_x^in_e mod in_m by sequencing an external
// Montgomery multiplier MM(a,b) = a*b*2^-N mod m through left-to-right binary
// exponentiation:
//   Xt = MM(x, R^2)            (into Montgomery domain)
//   A  = R mod m
//   for k = E_BITS-1 .. 0 : A = MM(A,A); if e[k] A = MM(A,Xt)
//   result = MM(A, 1)          (out of Montgomery domain)
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : request pulse, honoured only when idle
//   in_x/in_e/in_m       : base, exponent, odd modulus (latched on accept)
//   in_rmodm, in_r2modm  : 2^N mod m and 2^2N mod m
//   result, done, busy   : registered result, one-cycle done pulse, busy flag
//   mm_start, mm_a, mm_b, mm_m : multiplier request (registered)
//   mm_result, mm_done   : multiplier response
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int E_BITS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_rmodm,
    input  logic [N-1:0]      in_r2modm,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              busy,
    output logic              mm_start,
    output logic [N-1:0]      mm_a,
    output logic [N-1:0]      mm_b,
    output logic [N-1:0]      mm_m,
    input  logic [N-1:0]      mm_result,
    input  logic              mm_done
);

    localparam logic [N-1:0] ONE_N = N'(MM_ONE);

    modexp_state_t state_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  xt_reg;
    logic [N-1:0]  result_reg;
    logic          done_reg;
    logic          busy_reg;
    logic          mm_start_reg;
    logic [N-1:0]  mm_a_reg;
    logic [N-1:0]  mm_b_reg;
    logic [N-1:0]  mm_m_reg;

    logic          cur_bit;
    logic          last_bit;
    logic          scan_load;
    logic          scan_step;
    logic          wait_state;
    logic          mm_ret;
    modexp_state_t adv_state_next;
    logic [N-1:0]  adv_b_next;

    // A multiplier completion only counts while a multiply is outstanding:
    // in one of the four MM states and past its issue cycle.
    assign wait_state = (state_reg == ST_CONV_X) || (state_reg == ST_SQ) ||
                        (state_reg == ST_MUL)    || (state_reg == ST_CONV_OUT);
    assign mm_ret     = mm_done && wait_state && !mm_start_reg;

    assign scan_load  = (state_reg == ST_IDLE) && start;
    // k moves only when a bit is finished: after SQ of a 0-bit or after MUL.
    assign scan_step  = mm_ret && !last_bit &&
                        (((state_reg == ST_SQ) && !cur_bit) || (state_reg == ST_MUL));

    exp_scanner #(
        .E_BITS (E_BITS)
    ) u_scanner (
        .clk      (clk),
        .reset    (reset),
        .load     (scan_load),
        .step     (scan_step),
        .e_in     (in_e),
        .cur_bit  (cur_bit),
        .last_bit (last_bit)
    );

    // Where to go after a SQ/MUL result, and the B operand of that next
    // multiply. The A operand is always the fresh result.
    always_comb begin
        adv_state_next = ST_SQ;
        adv_b_next     = mm_result;
        if ((state_reg == ST_SQ) && cur_bit) begin
            adv_state_next = ST_MUL;
            adv_b_next     = xt_reg;
        end else if (last_bit) begin
            adv_state_next = ST_CONV_OUT;
            adv_b_next     = ONE_N;
        end
    end

    // Every transition into an MM state loads the operands and raises
    // mm_start on the same edge, so the issue cycle is the first cycle of
    // the new state and the operands stay put until the next mm_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            xt_reg       <= '0;
            result_reg   <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            mm_start_reg <= 1'b0;
            mm_a_reg     <= '0;
            mm_b_reg     <= '0;
            mm_m_reg     <= '0;
        end else begin
            mm_start_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_reg        <= in_rmodm;
                        mm_m_reg     <= in_m;
                        mm_a_reg     <= in_x;
                        mm_b_reg     <= in_r2modm;
                        mm_start_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_CONV_X;
                    end
                end
                ST_CONV_X: begin
                    if (mm_ret) begin
                        xt_reg       <= mm_result;
                        mm_a_reg     <= a_reg;
                        mm_b_reg     <= a_reg;
                        mm_start_reg <= 1'b1;
                        state_reg    <= ST_SQ;
                    end
                end
                ST_SQ, ST_MUL: begin
                    if (mm_ret) begin
                        a_reg        <= mm_result;
                        mm_a_reg     <= mm_result;
                        mm_b_reg     <= adv_b_next;
                        mm_start_reg <= 1'b1;
                        state_reg    <= adv_state_next;
                    end
                end
                ST_CONV_OUT: begin
                    if (mm_ret) begin
                        result_reg <= mm_result;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign result   = result_reg;
    assign done     = done_reg;
    assign busy     = busy_reg;
    assign mm_start = mm_start_reg;
    assign mm_a     = mm_a_reg;
    assign mm_b     = mm_b_reg;
    assign mm_m     = mm_m_reg;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: two instances (E_BITS = 16 and 1024, N = 1024),
// each served by a behavioural Montgomery multiplier with fixed or random
// latency. Results are compared against plain modular exponentiation.
module tb_modexp_ctrl;

    localparam int N   = 1024;
    localparam int EB0 = 16;
    localparam int EB1 = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rsts [2];
    logic           st   [2];
    logic [N-1:0]   ix   [2];
    logic [N-1:0]   im   [2];
    logic [N-1:0]   irm  [2];
    logic [N-1:0]   ir2  [2];
    logic [EB0-1:0] ie0;
    logic [EB1-1:0] ie1;
    logic [N-1:0]   res  [2];
    logic           don  [2];
    logic           bsy  [2];
    logic           mms  [2];
    logic [N-1:0]   mma  [2];
    logic [N-1:0]   mmb  [2];
    logic [N-1:0]   mmm  [2];
    logic [N-1:0]   mmr  [2];
    logic           mmd  [2];

    int mm_cnt [2];
    int gap_err [2];
    int extra_err [2];
    int unstable [2];
    int last_done [2];
    int lat_fix [2];

    int n_vec = 0;
    int n_bad = 0;

    modexp_ctrl #(.N(N), .E_BITS(EB0)) dut0 (
        .clk(clk), .reset(rsts[0]), .start(st[0]),
        .in_x(ix[0]), .in_e(ie0), .in_m(im[0]), .in_rmodm(irm[0]), .in_r2modm(ir2[0]),
        .result(res[0]), .done(don[0]), .busy(bsy[0]),
        .mm_start(mms[0]), .mm_a(mma[0]), .mm_b(mmb[0]), .mm_m(mmm[0]),
        .mm_result(mmr[0]), .mm_done(mmd[0])
    );

    modexp_ctrl #(.N(N), .E_BITS(EB1)) dut1 (
        .clk(clk), .reset(rsts[1]), .start(st[1]),
        .in_x(ix[1]), .in_e(ie1), .in_m(im[1]), .in_rmodm(irm[1]), .in_r2modm(ir2[1]),
        .result(res[1]), .done(don[1]), .busy(bsy[1]),
        .mm_start(mms[1]), .mm_a(mma[1]), .mm_b(mmb[1]), .mm_m(mmm[1]),
        .mm_result(mmr[1]), .mm_done(mmd[1])
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m);
        logic [2*N-1:0] t;
        logic [2*N-1:0] mw;
        mw = {{N{1'b0}}, m};
        t  = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % mw;
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] r_mod(input logic [N-1:0] m);
        logic [2*N-1:0] t;
        logic [2*N-1:0] mw;
        mw   = {{N{1'b0}}, m};
        t    = '0;
        t[N] = 1'b1;
        t    = t % mw;
        return t[N-1:0];
    endfunction

    // Montgomery product a*b*2^-N mod m by bit-serial reduction.
    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
        logic [2*N+1:0] t;
        logic [2*N+1:0] mw;
        mw = {{(N+2){1'b0}}, m};
        t  = {{(N+2){1'b0}}, a} * {{(N+2){1'b0}}, b};
        for (int i = 0; i < N; i++) begin
            if (t[0]) t = t + mw;
            t = t >> 1;
        end
        if (t >= mw) t = t - mw;
        return t[N-1:0];
    endfunction

    // Right-to-left square-and-multiply over the low ebits of e.
    function automatic logic [N-1:0] ref_modexp(input logic [N-1:0] x, input logic [EB1-1:0] e,
                                                input logic [N-1:0] m, input int ebits);
        logic [N-1:0] r;
        logic [N-1:0] p;
        r = '0;
        r[0] = 1'b1;
        p = x;
        for (int i = 0; i < ebits; i++) begin
            if (e[i]) r = mulmod(r, p, m);
            p = mulmod(p, p, m);
        end
        return r;
    endfunction

    function automatic int popcount(input logic [EB1-1:0] e, input int ebits);
        int c;
        c = 0;
        for (int i = 0; i < ebits; i++) if (e[i]) c++;
        return c;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check_w(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    task automatic mm_model(input int idx);
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
        int lat;
        bit aborted;
        mmd[idx] = 1'b0;
        mmr[idx] = '0;
        forever begin
            @(negedge clk);
            mmd[idx] = 1'b0;
            mmr[idx] = rand_wide();   // result lines carry junk outside mm_done
            if (rsts[idx] !== 1'b1 && mms[idx] === 1'b1) begin
                if (mm_cnt[idx] != 0 && cyc != last_done[idx] + 1) gap_err[idx]++;
                mm_cnt[idx]++;
                a = mma[idx];
                b = mmb[idx];
                m = mmm[idx];
                lat = (lat_fix[idx] != 0) ? lat_fix[idx] : int'($urandom_range(20, 2));
                aborted = 1'b0;
                for (int i = 1; i <= lat; i++) begin
                    if (!aborted) begin
                        @(negedge clk);
                        mmr[idx] = rand_wide();
                        if (rsts[idx] === 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            if (mms[idx] === 1'b1) extra_err[idx]++;
                            if (mma[idx] !== a || mmb[idx] !== b || mmm[idx] !== m) unstable[idx]++;
                            if (i == lat) begin
                                mmr[idx] = mont(a, b, m);
                                mmd[idx] = 1'b1;
                                last_done[idx] = cyc;
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial mm_model(0);
    initial mm_model(1);

    // ---------------- stimulus helpers ----------------
    task automatic drive_in(input int idx, input logic [N-1:0] x, input logic [EB1-1:0] e,
                            input logic [N-1:0] m);
        logic [N-1:0] rm;
        rm = r_mod(m);
        ix[idx]  = x;
        im[idx]  = m;
        irm[idx] = rm;
        ir2[idx] = mulmod(rm, rm, m);
        if (idx == 0) ie0 = e[EB0-1:0];
        else          ie1 = e;
    endtask

    task automatic run_op(input int idx, input logic [N-1:0] x, input logic [EB1-1:0] e,
                          input logic [N-1:0] m, input bit hold, input logic [N-1:0] exp_res,
                          input int exp_cnt, input string name);
        int budget;
        int cycles;
        bit busy_ok;
        budget = exp_cnt * 22 + 20;
        mm_cnt[idx]    = 0;
        gap_err[idx]   = 0;
        extra_err[idx] = 0;
        unstable[idx]  = 0;
        @(negedge clk);
        drive_in(idx, x, e, m);
        st[idx] = 1'b1;
        @(negedge clk);
        if (!hold) st[idx] = 1'b0;
        check_i({name, " T1 busy/mm_start"}, int'({bsy[idx], mms[idx]}), 3);
        busy_ok = 1'b1;
        cycles  = 0;
        while (don[idx] !== 1'b1 && cycles < budget) begin
            if (bsy[idx] !== 1'b1) busy_ok = 1'b0;
            if (hold) begin
                ix[idx]  = rand_wide();
                im[idx]  = rand_wide();
                irm[idx] = rand_wide();
                ir2[idx] = rand_wide();
                if (idx == 0) ie0 = 16'($urandom);
                else          ie1 = rand_wide();
            end
            @(negedge clk);
            cycles++;
        end
        st[idx] = 1'b0;
        check_i({name, " done seen"}, int'(don[idx]), 1);
        check_i({name, " busy held"}, int'(busy_ok && (bsy[idx] === 1'b1)), 1);
        check_w({name, " result"}, res[idx], exp_res);
        check_i({name, " mm_start count"}, mm_cnt[idx], exp_cnt);
        check_i({name, " done latency"}, cyc - last_done[idx], 1);
        check_i({name, " mm protocol errs"}, gap_err[idx] + extra_err[idx] + unstable[idx], 0);
        check_w({name, " mm_m"}, mmm[idx], m);
        @(negedge clk);
        check_i({name, " after done/busy"}, int'({don[idx], bsy[idx]}), 0);
        check_w({name, " result hold"}, res[idx], exp_res);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0]   m;
        logic [N-1:0]   x;
        logic [N-1:0]   rm;
        logic [EB1-1:0] e;
        int seen;
        int cycles;

        for (int i = 0; i < 2; i++) begin
            rsts[i] = 1'b1;
            st[i]   = 1'b0;
            ix[i]   = '0;
            im[i]   = '0;
            irm[i]  = '0;
            ir2[i]  = '0;
            mm_cnt[i] = 0;
            gap_err[i] = 0;
            extra_err[i] = 0;
            unstable[i] = 0;
            last_done[i] = 0;
        end
        ie0 = '0;
        ie1 = '0;
        lat_fix[0] = 3;
        lat_fix[1] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_w("reset result", res[i], '0);
            check_i("reset done/busy/mm_start", int'({don[i], bsy[i], mms[i]}), 0);
            check_w("reset mm_a|mm_b|mm_m", mma[i] | mmb[i] | mmm[i], '0);
        end
        rsts[0] = 1'b0;
        rsts[1] = 1'b0;

        // Hand-computed anchors for the reference arithmetic.
        m  = N'(497);
        rm = r_mod(m);
        check_w("pin mont(R mod m, 1)", mont(rm, N'(1), m), N'(1));
        check_w("pin 4^13 mod 497", ref_modexp(N'(4), EB1'(13), m, EB0), N'(445));
        check_w("pin 2^10 mod 497", ref_modexp(N'(2), EB1'(10), m, EB0), N'(30));

        // Base case, fixed latency 3 then random latency.
        run_op(0, N'(4), EB1'(13), m, 1'b0, N'(445), 21, "t1 lat3");
        lat_fix[0] = 0;
        run_op(0, N'(4), EB1'(13), m, 1'b0, N'(445), 21, "t1 latrand");
        lat_fix[0] = 3;

        // Exponent 0 and 1.
        run_op(0, N'(123), EB1'(0), m, 1'b0, N'(1), 18, "t2 e=0");
        run_op(0, N'(300), EB1'(1), m, 1'b0, N'(300), 19, "t3 e=1");

        // start held high and inputs churning throughout the operation.
        run_op(0, N'(4), EB1'(13), m, 1'b1, N'(445), 21, "t4 start held");

        // Reset in the 5th cycle of the first SQ.
        lat_fix[0]     = 8;
        mm_cnt[0]      = 0;
        @(negedge clk);
        drive_in(0, N'(4), EB1'(13), m);
        st[0] = 1'b1;
        @(negedge clk);
        st[0]  = 1'b0;
        seen   = (mms[0] === 1'b1) ? 1 : 0;
        cycles = 0;
        while (seen < 2 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (mms[0] === 1'b1) seen++;
        end
        check_i("t5 reached SQ", seen, 2);
        repeat (4) @(negedge clk);
        rsts[0] = 1'b1;
        @(negedge clk);
        check_i("t5 reset done/busy/mm_start", int'({don[0], bsy[0], mms[0]}), 0);
        check_w("t5 reset result", res[0], '0);
        check_w("t5 reset mm_a|mm_b|mm_m", mma[0] | mmb[0] | mmm[0], '0);
        @(negedge clk);
        rsts[0]    = 1'b0;
        lat_fix[0] = 3;
        run_op(0, N'(4), EB1'(13), m, 1'b0, N'(445), 21, "t5 restart");

        // Random wide operands, 16-bit exponents, random latency.
        lat_fix[0] = 0;
        for (int k = 0; k < 3; k++) begin
            m = rand_wide();
            m[0] = 1'b1;
            m[N-1] = 1'b1;
            x = rand_wide() % m;
            e = '0;
            e[EB0-1:0] = 16'($urandom);
            run_op(0, x, e, m, 1'b0, ref_modexp(x, e, m, EB0), 2 + EB0 + popcount(e, EB0),
                   "rand16");
        end

        // Full-width exponent.
        m = rand_wide();
        m[0] = 1'b1;
        m[N-1] = 1'b1;
        x = rand_wide() % m;
        e = rand_wide();
        run_op(1, x, e, m, 1'b0, ref_modexp(x, e, m, EB1), 2 + EB1 + popcount(e, EB1),
               "t6 e1024");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
